// File: rtl/dff_reg_share_arbiter.sv
// dff_reg_share_arbiter
// Round-robin arbiter that shares one complementary-output storage register
// (Q1 = data, Q2 = ~data) among N_REQ requesters using a req/gnt/ack handshake.
// Each transaction runs IDLE -> GRANT -> WRITE, and the winner's data lands in Q1
// on the edge that enters WRITE. All handshake outputs are registered.
// Optional feature: define DFF_ARB_PARITY_EN to add a registered 'parity' output
// that tracks ^Q1.

module dff_reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [2:0]             owner,
  output logic [WIDTH-1:0]       Q1,
  output logic [WIDTH-1:0]       Q2
`ifdef DFF_ARB_PARITY_EN
  ,
  output logic                   parity
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   arb_idx;
  logic [IW-1:0]   cand;
  logic            found;
  logic [N_REQ-1:0] gnt_d;
  logic [N_REQ-1:0] ack_d;
  logic            busy_d;
  logic [2:0]      owner_d;
  logic [WIDTH-1:0] q1_d;
  logic [WIDTH-1:0] win_data;
`ifdef DFF_ARB_PARITY_EN
  logic            parity_d;
`endif

  // Q2 is derived from the single stored copy so the complement holds every cycle, reset included.
  assign Q2 = ~Q1;

  // The current winner's data slice; only consumed on the GRANT -> WRITE edge.
  assign win_data = wdata[int'(win_q)*WIDTH +: WIDTH];

  // Round-robin search: first set request scanning last+1, last+2, ... wrapping modulo N_REQ.
  always_comb begin
    arb_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % N_REQ);
      if (!found && req[cand]) begin
        arb_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; everything falls back to hold or idle values first.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = '0;
    ack_d   = '0;
    owner_d = owner;
    q1_d    = Q1;
`ifdef DFF_ARB_PARITY_EN
    parity_d = parity;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d        = GRANT;
          win_d          = arb_idx;
          gnt_d[arb_idx] = 1'b1;
        end
      end
      GRANT: begin
        if (req[win_q]) begin
          state_d      = WRITE;
          ack_d[win_q] = 1'b1;
          owner_d      = 3'(win_q);
          last_d       = win_q;
          q1_d         = win_data;
`ifdef DFF_ARB_PARITY_EN
          parity_d     = ^win_data;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer and output registers; reset aborts any handshake in flight.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      gnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      owner   <= 3'd0;
      Q1      <= '0;
`ifdef DFF_ARB_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      ack     <= ack_d;
      busy    <= busy_d;
      owner   <= owner_d;
      Q1      <= q1_d;
`ifdef DFF_ARB_PARITY_EN
      parity  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_dff_reg_share_arbiter.sv
// tb_dff_reg_share_arbiter
// Directed bench for dff_reg_share_arbiter with N_REQ=4, WIDTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
// Define DFF_ARB_PARITY_EN to also exercise the parity output.

module tb_dff_reg_share_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;

  logic                   CLK;
  logic                   RST_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic [2:0]             owner;
  logic [WIDTH-1:0]       Q1;
  logic [WIDTH-1:0]       Q2;
`ifdef DFF_ARB_PARITY_EN
  logic                   parity;
`endif

  int errors = 0;
  int checks = 0;

  dff_reg_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .busy  (busy),
    .owner (owner),
    .Q1    (Q1),
    .Q2    (Q2)
`ifdef DFF_ARB_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  // 10-unit clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    req   = '0;
    RST_n = 1'b0;
    step();
    step();
    RST_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    req   = '0;
    wdata = '0;
    #2;
    checks++; if (Q1 !== 8'h00) begin errors++; $display("[TB] FAIL rst_q1: got %h expected %h", Q1, 8'h00); end
    checks++; if (Q2 !== 8'hFF) begin errors++; $display("[TB] FAIL rst_q2: got %h expected %h", Q2, 8'hFF); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rst_gnt: got %b expected %b", gnt, 4'b0000); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ack: got %b expected %b", ack, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (owner !== 3'd0) begin errors++; $display("[TB] FAIL rst_owner: got %0d expected %0d", owner, 0); end
    step();
    RST_n = 1'b1;
    // Start a write from requester 1 and hit reset in its WRITE cycle.
    wdata = 32'h0000_3C00;
    req   = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL rstw_gnt: got %b expected %b", gnt, 4'b0010); end
    step();
    checks++; if (Q1 !== 8'h3C) begin errors++; $display("[TB] FAIL rstw_q1_pre: got %h expected %h", Q1, 8'h3C); end
    RST_n = 1'b0;
    #1;
    checks++; if (Q1 !== 8'h00) begin errors++; $display("[TB] FAIL rstw_q1: got %h expected %h", Q1, 8'h00); end
    checks++; if (Q2 !== 8'hFF) begin errors++; $display("[TB] FAIL rstw_q2: got %h expected %h", Q2, 8'hFF); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rstw_gnt0: got %b expected %b", gnt, 4'b0000); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL rstw_ack: got %b expected %b", ack, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw_busy: got %b expected %b", busy, 1'b0); end
    req = '0;
    step();
    RST_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    wdata = 32'h00A5_0000;
    req   = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL t2_gnt: got %b expected %b", gnt, 4'b0100); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t2_busy_g: got %b expected %b", busy, 1'b1); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL t2_ack_g: got %b expected %b", ack, 4'b0000); end
    step();
    checks++; if (Q1 !== 8'hA5) begin errors++; $display("[TB] FAIL t2_q1: got %h expected %h", Q1, 8'hA5); end
    checks++; if (Q2 !== 8'h5A) begin errors++; $display("[TB] FAIL t2_q2: got %h expected %h", Q2, 8'h5A); end
    checks++; if (ack !== 4'b0100) begin errors++; $display("[TB] FAIL t2_ack: got %b expected %b", ack, 4'b0100); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL t2_gnt_w: got %b expected %b", gnt, 4'b0000); end
    checks++; if (owner !== 3'd2) begin errors++; $display("[TB] FAIL t2_owner: got %0d expected %0d", owner, 2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t2_busy_w: got %b expected %b", busy, 1'b1); end
    req = '0;
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL t2_ack_end: got %b expected %b", ack, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_busy_end: got %b expected %b", busy, 1'b0); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ack;
    logic [7:0] exp_q1;
    int k;
    apply_reset();
    wdata = 32'h4433_2211;
    req   = 4'b1111;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_ack = 4'b0000;
      if (n % 3 == 2) begin
        k       = (n - 2) / 3;
        exp_ack = 4'(1 << k);
        exp_q1  = 8'(8'h11 * (k + 1));
        checks++; if (Q1 !== exp_q1) begin errors++; $display("[TB] FAIL t3_q1 n=%0d: got %h expected %h", n, Q1, exp_q1); end
        checks++; if (owner !== 3'(k)) begin errors++; $display("[TB] FAIL t3_owner n=%0d: got %0d expected %0d", n, owner, k); end
      end
      checks++; if (ack !== exp_ack) begin errors++; $display("[TB] FAIL t3_ack n=%0d: got %b expected %b", n, ack, exp_ack); end
    end
    req = '0;
    step();
  endtask

  task automatic test_abort();
    req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL t4_gnt: got %b expected %b", gnt, 4'b0010); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL t4_gnt_ab: got %b expected %b", gnt, 4'b0000); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL t4_ack: got %b expected %b", ack, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t4_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (Q1 !== 8'h44) begin errors++; $display("[TB] FAIL t4_q1: got %h expected %h", Q1, 8'h44); end
    req = 4'b0011;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL t4_regnt: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    step();
    // Pointer still at 3 after two aborts, so requester 1 beats requester 2.
    req = 4'b0110;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL t4_last: got %b expected %b", gnt, 4'b0010); end
    req = 4'b0000;
    step();
    checks++; if (Q1 !== 8'h44) begin errors++; $display("[TB] FAIL t4_q1_end: got %h expected %h", Q1, 8'h44); end
  endtask

  task automatic test_wrap();
    wdata = 32'h0300_00C7;
    req   = 4'b1001;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL t5_gnt0: got %b expected %b", gnt, 4'b0001); end
    step();
    checks++; if (ack !== 4'b0001) begin errors++; $display("[TB] FAIL t5_ack0: got %b expected %b", ack, 4'b0001); end
    checks++; if (Q1 !== 8'hC7) begin errors++; $display("[TB] FAIL t5_q1_0: got %h expected %h", Q1, 8'hC7); end
    checks++; if (owner !== 3'd0) begin errors++; $display("[TB] FAIL t5_owner0: got %0d expected %0d", owner, 0); end
    req = 4'b0000;
    step();
    req = 4'b1001;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL t5_gnt3: got %b expected %b", gnt, 4'b1000); end
    step();
    checks++; if (ack !== 4'b1000) begin errors++; $display("[TB] FAIL t5_ack3: got %b expected %b", ack, 4'b1000); end
    checks++; if (Q1 !== 8'h03) begin errors++; $display("[TB] FAIL t5_q1_3: got %h expected %h", Q1, 8'h03); end
    checks++; if (Q2 !== 8'hFC) begin errors++; $display("[TB] FAIL t5_q2_3: got %h expected %h", Q2, 8'hFC); end
    checks++; if (owner !== 3'd3) begin errors++; $display("[TB] FAIL t5_owner3: got %0d expected %0d", owner, 3); end
    req = 4'b0000;
    step();
  endtask

`ifdef DFF_ARB_PARITY_EN
  task automatic test_parity();
    wdata = 32'h0300_0007;
    req   = 4'b0001;
    step();
    step();
    checks++; if (parity !== 1'b1) begin errors++; $display("[TB] FAIL t6_par07: got %b expected %b", parity, 1'b1); end
    req = 4'b0000;
    step();
    req = 4'b1000;
    step();
    step();
    checks++; if (parity !== 1'b0) begin errors++; $display("[TB] FAIL t6_par03: got %b expected %b", parity, 1'b0); end
    req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    $display("[TB] starting dff_reg_share_arbiter bench");
    test_reset();
    test_single_write();
    test_fairness();
    test_abort();
    test_wrap();
`ifdef DFF_ARB_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
